// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard sequencing, operand forwarding and stall counting
//
// Purpose: drives the PC and pipeline-register enables and flushes of the 10-bit core.
// It resolves load-use, multi-cycle RAM and taken-branch hazards, generates the EX
// operand forwarding selects, and keeps a saturating count of stalled cycles.
//
// Ports:
//   clk, reset                        rising-edge clock, async active-high reset
//   id_rs_addr/id_rt_addr/id_uses_*   source operands of the ID instruction
//   ex_rs_addr/ex_rt_addr             source operands of the EX instruction
//   ex_dest_addr/ex_mem_re/ex_reg_wb  destination and kind of the EX instruction
//   ex_mem_req, mem_ready             RAM request and completion handshake
//   mem_dest_addr/mem_reg_wb/mem_re   writeback info of the Exe/Mem/WB register
//   branch_taken                      branch resolved taken in EX
//   pc_en, if_id_en, id_ex_en, exe_mem_wb_en   pipeline enables
//   if_id_flush, id_ex_flush          bubble insertion
//   fwd_a, fwd_b                      00 regfile, 01 alu_result_out, 10 ram_rdata_out
//   mem_timeout                       sticky RAM timeout flag
//   stall_cycles                      saturating stalled-cycle count
module pipeline_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  id_rs_addr,
  input  logic [2:0]  id_rt_addr,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [2:0]  ex_rs_addr,
  input  logic [2:0]  ex_rt_addr,
  input  logic [2:0]  ex_dest_addr,
  input  logic        ex_mem_re,
  input  logic        ex_reg_wb,
  input  logic        ex_mem_req,
  input  logic        mem_ready,
  input  logic [2:0]  mem_dest_addr,
  input  logic        mem_reg_wb,
  input  logic        mem_re,
  input  logic        branch_taken,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        exe_mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_MAX);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic        load_use;

  // All eight registers are compared; r0 is an ordinary register in this core.
  assign load_use = ex_mem_re && ex_reg_wb &&
                    ((id_uses_rs && (ex_dest_addr == id_rs_addr)) ||
                     (id_uses_rt && (ex_dest_addr == id_rt_addr)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      wait_cnt_q   <= 4'd0;
      timeout_q    <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      // pc_en here is the value held throughout the cycle now ending.
      if (!pc_en && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = timeout_q;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    exe_mem_wb_en = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;

    case (state_q)
      RUN: begin
        if (ex_mem_req && !mem_ready) begin
          // Freeze beats a simultaneous branch; the branch is taken on completion.
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_ex_en      = 1'b0;
          exe_mem_wb_en = 1'b0;
          state_d       = MEM_WAIT;
          wait_cnt_d    = 4'd1;
        end else if (branch_taken) begin
          // The flush also squashes any load-use dependent, so no PC hold is needed.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (mem_ready) begin
          if_id_flush = branch_taken;
          id_ex_flush = branch_taken;
          state_d     = RUN;
        end else begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_ex_en      = 1'b0;
          exe_mem_wb_en = 1'b0;
          if (wait_cnt_q == WAIT_LIMIT) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
      end

      default: begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        exe_mem_wb_en = 1'b0;
        timeout_d     = 1'b1;
        state_d       = ERROR;
      end
    endcase
  end

  assign mem_timeout = timeout_q;

  function automatic logic [1:0] fwd_sel(input logic [2:0] addr, input logic [2:0] dest,
                                         input logic wb, input logic re);
    if (wb && (dest == addr)) begin
      return re ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(ex_rs_addr, mem_dest_addr, mem_reg_wb, mem_re);
  assign fwd_b = fwd_sel(ex_rt_addr, mem_dest_addr, mem_reg_wb, mem_re);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, ex_dest_addr, mem_dest_addr;
  logic        id_uses_rs, id_uses_rt, ex_mem_re, ex_reg_wb, ex_mem_req, mem_ready;
  logic        mem_reg_wb, mem_re, branch_taken;
  logic        pc_en, if_id_en, id_ex_en, exe_mem_wb_en, if_id_flush, id_ex_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        mem_timeout;
  logic [15:0] stall_cycles;
  logic [5:0]  ctl;

  int checks = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(.WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_dest_addr(ex_dest_addr),
    .ex_mem_re(ex_mem_re), .ex_reg_wb(ex_reg_wb), .ex_mem_req(ex_mem_req),
    .mem_ready(mem_ready), .mem_dest_addr(mem_dest_addr),
    .mem_reg_wb(mem_reg_wb), .mem_re(mem_re), .branch_taken(branch_taken),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .exe_mem_wb_en(exe_mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  // {pc_en, if_id_en, id_ex_en, exe_mem_wb_en, if_id_flush, id_ex_flush}
  assign ctl = {pc_en, if_id_en, id_ex_en, exe_mem_wb_en, if_id_flush, id_ex_flush};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs_addr = 3'd0; id_rt_addr = 3'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_rs_addr = 3'd0; ex_rt_addr = 3'd0; ex_dest_addr = 3'd0;
    ex_mem_re = 1'b0; ex_reg_wb = 1'b0; ex_mem_req = 1'b0; mem_ready = 1'b0;
    mem_dest_addr = 3'd0; mem_reg_wb = 1'b0; mem_re = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    #12;
    check("reset_ctl", 16'(ctl), 16'h3C);
    check("reset_fwd", 16'({fwd_a, fwd_b}), 16'h0);
    check("reset_stall", stall_cycles, 16'd0);
    check("reset_timeout", 16'(mem_timeout), 16'd0);
    @(negedge clk); reset = 1'b0;

    // load-use on rs: one bubble
    @(negedge clk);
    ex_mem_re = 1'b1; ex_reg_wb = 1'b1; ex_dest_addr = 3'd3; id_rs_addr = 3'd3; id_uses_rs = 1'b1;
    #1 check("lu_rs_ctl", 16'(ctl), 16'h0D);
    @(negedge clk);
    clear_inputs();
    mem_re = 1'b1; mem_reg_wb = 1'b1; mem_dest_addr = 3'd3; ex_rs_addr = 3'd3;
    #1 check("lu_fwd_a", 16'(fwd_a), 16'h2);
    check("lu_after_ctl", 16'(ctl), 16'h3C);
    check("lu_stall", stall_cycles, 16'd1);

    // load-use on rt with r0
    @(negedge clk);
    clear_inputs();
    ex_mem_re = 1'b1; ex_reg_wb = 1'b1; ex_dest_addr = 3'd0; id_rt_addr = 3'd0; id_uses_rt = 1'b1;
    #1 check("lu_r0_ctl", 16'(ctl), 16'h0D);
    // address match but operand unused
    @(negedge clk);
    clear_inputs();
    ex_mem_re = 1'b1; ex_reg_wb = 1'b1; ex_dest_addr = 3'd6; id_rt_addr = 3'd6;
    #1 check("lu_unused_ctl", 16'(ctl), 16'h3C);
    check("lu_r0_stall", stall_cycles, 16'd2);
    // load without register writeback
    @(negedge clk);
    clear_inputs();
    ex_mem_re = 1'b1; ex_dest_addr = 3'd6; id_rs_addr = 3'd6; id_uses_rs = 1'b1;
    #1 check("lu_nowb_ctl", 16'(ctl), 16'h3C);

    // forwarding
    @(negedge clk);
    clear_inputs();
    mem_reg_wb = 1'b1; mem_dest_addr = 3'd5; ex_rt_addr = 3'd5; ex_rs_addr = 3'd2;
    #1 check("fwd_b_alu", 16'(fwd_b), 16'h1);
    check("fwd_a_none", 16'(fwd_a), 16'h0);
    mem_reg_wb = 1'b0;
    #1 check("fwd_nowb", 16'({fwd_a, fwd_b}), 16'h0);
    mem_reg_wb = 1'b1; mem_re = 1'b1; mem_dest_addr = 3'd4; ex_rs_addr = 3'd4; ex_rt_addr = 3'd4;
    #1 check("fwd_both_ram", 16'({fwd_a, fwd_b}), 16'hA);

    // memory wait, 3 cycles
    @(negedge clk);
    clear_inputs();
    ex_mem_req = 1'b1;
    #1 check("mw_c0", 16'(ctl), 16'h00);
    @(negedge clk); #1 check("mw_c1", 16'(ctl), 16'h00);
    @(negedge clk); #1 check("mw_c2", 16'(ctl), 16'h00);
    @(negedge clk); mem_ready = 1'b1;
    #1 check("mw_done", 16'(ctl), 16'h3C);
    @(negedge clk); clear_inputs();
    #1 check("mw_run", 16'(ctl), 16'h3C);
    check("mw_stall", stall_cycles, 16'd5);

    // ready on the request cycle
    ex_mem_req = 1'b1; mem_ready = 1'b1;
    #1 check("mr_same_ctl", 16'(ctl), 16'h3C);

    // branch with load-use
    @(negedge clk);
    clear_inputs();
    branch_taken = 1'b1; ex_mem_re = 1'b1; ex_reg_wb = 1'b1; ex_dest_addr = 3'd3;
    id_rs_addr = 3'd3; id_uses_rs = 1'b1;
    #1 check("br_lu_ctl", 16'(ctl), 16'h3F);
    @(negedge clk); clear_inputs();
    #1 check("br_lu_stall", stall_cycles, 16'd5);

    // branch with memory stall
    ex_mem_req = 1'b1; branch_taken = 1'b1;
    #1 check("br_mem_freeze", 16'(ctl), 16'h00);
    @(negedge clk); mem_ready = 1'b1;
    #1 check("br_mem_done", 16'(ctl), 16'h3F);
    @(negedge clk); clear_inputs();
    #1 check("br_mem_run", 16'(ctl), 16'h3C);
    check("br_mem_stall", stall_cycles, 16'd6);

    // timeout with WAIT_MAX=4
    @(negedge clk);
    ex_mem_req = 1'b1;
    #1 check("to_c0", 16'(ctl), 16'h00);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1 check($sformatf("to_wait%0d_flag", i), 16'(mem_timeout), 16'd0);
    end
    @(negedge clk);
    #1 check("to_flag", 16'(mem_timeout), 16'd1);
    check("to_ctl", 16'(ctl), 16'h00);
    check("to_stall", stall_cycles, 16'd11);
    mem_ready = 1'b1; branch_taken = 1'b1;
    #1 check("err_ignore", 16'(ctl), 16'h00);
    @(negedge clk);
    #1 check("err_sticky", 16'(mem_timeout), 16'd1);
    check("err_stall", stall_cycles, 16'd12);
    #2 clear_inputs(); reset = 1'b1;
    #1 check("async_rst_flag", 16'(mem_timeout), 16'd0);
    check("async_rst_stall", stall_cycles, 16'd0);
    check("async_rst_ctl", 16'(ctl), 16'h3C);
    @(negedge clk); reset = 1'b0;

    // saturation: park in ERROR for 70000 cycles
    @(negedge clk);
    ex_mem_req = 1'b1;
    repeat (5) @(negedge clk);
    #1 check("sat_err_flag", 16'(mem_timeout), 16'd1);
    check("sat_start", stall_cycles, 16'd5);
    repeat (70000) @(negedge clk);
    #1 check("sat_hold", stall_cycles, 16'hFFFF);
    repeat (3) @(negedge clk);
    #1 check("sat_nowrap", stall_cycles, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the 10-bit pipelined core. It drives the enable and flush controls of the IF/ID, ID/EX and Exe/Mem/WB pipeline registers and the PC, and it generates the EX-stage operand forwarding selects. It handles three hazards: load-use dependencies, multi-cycle RAM accesses, and taken branches. It also keeps a saturating stall-cycle counter.

## Interface
- WAIT_MAX, 15: maximum number of MEM_WAIT cycles before a timeout is declared. Legal range is 1..15; the counter is 4 bits.
- clk  in  1  core clock. The controller state updates on the rising edge. The pipeline registers latch on the falling edge (~clk).
- reset  in  1  asynchronous, active-high.
- id_rs_addr, id_rt_addr  in  3 each  source register addresses of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction actually reads that source.
- ex_rs_addr, ex_rt_addr  in  3 each  source register addresses of the instruction in EX.
- ex_dest_addr  in  3  destination register of the EX instruction.
- ex_mem_re, ex_reg_wb  in  1 each  the EX instruction is a load / writes the register file.
- ex_mem_req  in  1  the EX instruction accesses RAM (load or store).
- mem_ready  in  1  RAM handshake: the access completes this cycle.
- mem_dest_addr  in  3  gp_rdata2_address_out of the Exe/Mem/WB register.
- mem_reg_wb, mem_re  in  1 each  gp_reg_wb_out and mem_re_out of the Exe/Mem/WB register.
- branch_taken  in  1  a branch resolved taken in EX.
- pc_en, if_id_en, id_ex_en, exe_mem_wb_en  out  1 each  pipeline register enables.
- if_id_flush, id_ex_flush  out  1 each  insert a bubble (zero the register) at the next latch.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 = register file, 01 = alu_result_out, 10 = ram_rdata_out.
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  16  saturating count of frozen or bubbled cycles.

## Operation
- FSM states are RUN, MEM_WAIT and ERROR. There is a 4-bit wait_cnt.
- RUN, evaluated in this priority order:
  1. Memory stall: ex_mem_req=1 and mem_ready=0. All four enables are 0 and there are no flushes. Next state is MEM_WAIT and wait_cnt is set to 1.
  2. Branch: branch_taken=1. All enables are 1, if_id_flush=1 and id_ex_flush=1. State stays RUN.
  3. Load-use: ex_mem_re=1, ex_reg_wb=1, and ex_dest_addr matches id_rs_addr with id_uses_rs=1, or matches id_rt_addr with id_uses_rt=1. Outputs are pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1 and exe_mem_wb_en=1. This gives exactly one bubble. State stays RUN.
  4. Otherwise all enables are 1 and both flushes are 0.
- Register 0 gets no special treatment; all 8 registers are compared.
- MEM_WAIT:
  - Every enable is 0 and every flush is 0.
  - If mem_ready=1: enables are 1 this cycle and next state is RUN. A branch_taken arriving in that same cycle is honoured (both flushes asserted).
  - Else if wait_cnt = WAIT_MAX: next state is ERROR and mem_timeout is set.
  - Else wait_cnt increments.
- ERROR:
  - All enables are 0 and mem_timeout=1. Only reset exits.
  - Other inputs are ignored.
- Forwarding is purely combinational and independent of state. Evaluated per operand, fwd_a for ex_rs_addr and fwd_b for ex_rt_addr:
  - mem_reg_wb=1 and mem_dest_addr equals the operand address: select 10 if mem_re=1, else 01.
  - Otherwise select 00.
- stall_cycles:
  - Increments on each rising edge where pc_en was 0 during the preceding cycle.
  - Saturates at 0xFFFF and never wraps.
  - ERROR cycles count.

## Timing
- Reset, asynchronous: state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0.
- With no hazard present during reset, outputs are: all enables 1, flushes 0, fwd 00.
- State, wait_cnt, mem_timeout and stall_cycles update on the rising edge of clk.
- Enables, flushes and fwd are Mealy outputs of state and inputs. They must settle within half a cycle so the falling-edge pipeline registers sample them correctly.
- Latencies:
  - Load-use costs exactly 1 bubble cycle.
  - A memory access whose mem_ready arrives N cycles after ex_mem_req costs N frozen cycles.
  - A branch costs 2 flushed slots and 0 frozen cycles.
- Boundary conditions:
  - Simultaneous memory stall and branch: freeze wins. The branch is honoured on the completion cycle.
  - Simultaneous branch and load-use: flush only, with no PC hold.
  - mem_ready=1 on the cycle ex_mem_req rises: no stall.
  - Reset in MEM_WAIT or ERROR: returns to RUN immediately, without waiting for a clock edge.

## Test plan
- Load-use: lw r3 in EX (ex_mem_re=1, ex_reg_wb=1, ex_dest_addr=3) with an ID instruction reading r3 (id_uses_rs=1) -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1. Next cycle mem_re=1, mem_dest_addr=3, ex_rs_addr=3 -> fwd_a=10. stall_cycles=1.
- Forwarding: mem_reg_wb=1, mem_re=0, mem_dest_addr=5, ex_rt_addr=5, ex_rs_addr=2 -> fwd_b=01, fwd_a=00. Same stimulus with mem_reg_wb=0 -> both 00.
- Memory wait: ex_mem_req=1 with mem_ready held low 3 cycles then high -> 3 frozen cycles, then enables all 1 and state RUN. stall_cycles=3.
- Timeout: WAIT_MAX=4, mem_ready stuck at 0 -> ERROR after the 4th MEM_WAIT cycle with mem_timeout=1. Flag stays set; async reset mid-cycle clears it immediately.
- Branch priority: branch_taken=1 together with a load-use match -> both flushes 1, pc_en=1. branch_taken=1 together with a memory stall -> freeze, then flushes on the mem_ready cycle.
- Saturation: force 70000 consecutive stall cycles -> stall_cycles holds at 0xFFFF.
